// File: rtl/change_pkg.sv
// change_pkg: coin and state types plus coin value helper for the change dispenser
package change_pkg;
  typedef enum logic [1:0] {COIN1 = 2'd0, COIN2 = 2'd1, COIN5 = 2'd2} coin_t;
  typedef enum logic [1:0] {IDLE, SELECT, REQ, FINISH} state_t;
  function automatic logic [3:0] coin_value(coin_t c);
    return c == COIN5 ? 4'd5 : c == COIN2 ? 4'd2 : c == COIN1 ? 4'd1 : 4'd0;
  endfunction
endpackage

// File: rtl/change_dispenser_ctrl_if.sv
// change_dispenser_ctrl_if: vending-FSM, refill and hopper signals of the change dispenser
interface change_dispenser_ctrl_if #(parameter int INV_W = 4);
  logic             start;
  logic [3:0]       amount;
  logic             refill;
  logic [1:0]       refill_coin;
  logic [INV_W-1:0] refill_count;
  logic             eject_req;
  logic [1:0]       eject_sel;
  logic             eject_ack;
  logic             busy;
  logic             done;
  logic             short;
  logic [3:0]       remaining;
  logic [INV_W-1:0] inv_1;
  logic [INV_W-1:0] inv_2;
  logic [INV_W-1:0] inv_5;
  modport master (
    input  start, amount, refill, refill_coin, refill_count, eject_ack,
    output eject_req, eject_sel, busy, done, short, remaining, inv_1, inv_2, inv_5
  );
  modport slave (
    output start, amount, refill, refill_coin, refill_count, eject_ack,
    input  eject_req, eject_sel, busy, done, short, remaining, inv_1, inv_2, inv_5
  );
endinterface

// File: rtl/coin_inventory.sv
// coin_inventory: one denomination's coin count with saturating refill and guarded decrement
module coin_inventory #(
  parameter int INV_W = 4,
  parameter int INIT  = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             add,
  input  logic             dec,
  input  logic [INV_W-1:0] add_count,
  output logic [INV_W-1:0] count
);
  logic [INV_W:0] sum;
  assign sum = {1'b0, count} + (add ? {1'b0, add_count} : '0) - {{INV_W{1'b0}}, dec && count != '0};
  always_ff @(posedge CLK or posedge reset)
    if (reset) count <= INIT[INV_W-1:0];
    else count <= sum[INV_W] ? '1 : sum[INV_W-1:0];
endmodule

// File: rtl/change_dispenser_ctrl.sv
// change_dispenser_ctrl: greedy change sequencer driving a one-coin-per-handshake hopper
module change_dispenser_ctrl
  import change_pkg::*;
#(
  parameter int INV_W  = 4,
  parameter int INIT_1 = 4,
  parameter int INIT_2 = 4,
  parameter int INIT_5 = 4
) (
  input logic CLK,
  input logic reset,
  change_dispenser_ctrl_if.master bus
);
  state_t           state;
  coin_t            sel;
  coin_t            pick;
  logic [3:0]       rem;
  logic             req, bsy, dn, sht;
  logic             can5, can2, can1;
  logic [INV_W-1:0] inv [3];
  for (genvar i = 0; i < 3; i++) begin : g_inv
    coin_inventory #(
      .INV_W(INV_W),
      .INIT (i == 0 ? INIT_1 : i == 1 ? INIT_2 : INIT_5)
    ) u_inv (
      .CLK      (CLK),
      .reset    (reset),
      .add      (bus.refill && bus.refill_coin == 2'(i)),
      .dec      (state == REQ && bus.eject_ack && sel == 2'(i)),
      .add_count(bus.refill_count),
      .count    (inv[i])
    );
  end
  // rem is known nonzero whenever pick is used, so a 1-ruble coin always fits
  assign can5 = rem >= 4'd5 && inv[2] != '0;
  assign can2 = rem >= 4'd2 && inv[1] != '0;
  assign can1 = inv[0] != '0;
  assign pick = can5 ? COIN5 : can2 ? COIN2 : COIN1;
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      state <= IDLE;
      sel   <= COIN1;
      rem   <= '0;
      req   <= 1'b0;
      bsy   <= 1'b0;
      dn    <= 1'b0;
      sht   <= 1'b0;
    end else begin
      dn <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          rem   <= bus.amount;
          sht   <= 1'b0;
          bsy   <= 1'b1;
          state <= SELECT;
        end
        SELECT: if (rem == '0) begin
          dn    <= 1'b1;
          state <= FINISH;
        end else if (can5 || can2 || can1) begin
          sel   <= pick;
          req   <= 1'b1;
          state <= REQ;
        end else begin
          sht   <= 1'b1;
          dn    <= 1'b1;
          state <= FINISH;
        end
        REQ: if (bus.eject_ack) begin
          req   <= 1'b0;
          rem   <= rem - coin_value(sel);
          state <= SELECT;
        end
        FINISH: begin
          bsy   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  assign bus.eject_req = req;
  assign bus.eject_sel = sel;
  assign bus.busy      = bsy;
  assign bus.done      = dn;
  assign bus.short     = sht;
  assign bus.remaining = rem;
  assign bus.inv_1     = inv[0];
  assign bus.inv_2     = inv[1];
  assign bus.inv_5     = inv[2];
endmodule
